// File: rtl/rx_slip_demod.sv
// Baseband VLC receiver: DC-tracking slicer, one-sample slip symbol timing recovery,
// sync-word hunt and payload bit counting with a sticky frame-complete flag.
module rx_slip_demod #(
    parameter int          WIDTH        = 10,
    parameter int          SPS          = 8,
    parameter int          THR_SHIFT    = 4,
    parameter logic [15:0] SYNC_WORD    = 16'hA5C3,
    parameter int          PAYLOAD_BITS = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_rx_in,
    output logic             o_done_ind,
    output logic             o_bit,
    output logic             o_bit_valid,
    output logic             o_locked
);
    localparam int ACC_W = WIDTH + THR_SHIFT;
    localparam int HALF  = SPS / 2;
    localparam int CW    = $clog2(SPS + 2);
    localparam int BCW   = $clog2(PAYLOAD_BITS + 1);
    localparam logic [ACC_W-1:0] ACC_MID  = ACC_W'(1) << (ACC_W - 1);
    localparam logic [CW-1:0]    SPS_C    = CW'(SPS);
    localparam logic [CW-1:0]    HALF_C   = CW'(HALF);
    localparam logic [BCW-1:0]   LAST_BIT = BCW'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [WIDTH-1:0] thr;
    logic             slice;
    logic [CW-1:0]    phase;
    logic [CW-1:0]    win_len;
    logic [CW-1:0]    ones_cnt;
    logic [CW-1:0]    first_cnt;
    logic [CW-1:0]    ones_tot;
    logic [CW-1:0]    first_tot;
    logic [CW-1:0]    last_ones;
    logic [CW-1:0]    e_cnt;
    logic [CW-1:0]    l_cnt;
    logic [CW-1:0]    next_len;
    logic [HALF-2:0]  hist;
    logic [HALF-1:0]  hist_ext;
    logic [14:0]      shreg;
    logic [15:0]      new_shreg;
    logic [BCW-1:0]   bit_cnt;
    logic             win_end;
    logic             b;

    always_comb begin
        thr      = acc[ACC_W-1:THR_SHIFT];
        slice    = (i_rx_in >= thr);
        // acc >= thr << THR_SHIFT, so the subtraction cannot underflow
        acc_next = ACC_W'({1'b0, acc} + (ACC_W+1)'(i_rx_in) - (ACC_W+1)'(thr));

        ones_tot  = ones_cnt + CW'(slice);
        first_tot = first_cnt + ((phase < HALF_C) ? CW'(slice) : '0);
        hist_ext  = {hist, slice};
        last_ones = '0;
        for (int i = 0; i < HALF; i++) begin
            last_ones = last_ones + CW'(hist_ext[i]);
        end

        b     = (ones_tot > HALF_C);
        e_cnt = b ? (HALF_C - first_tot) : first_tot;
        l_cnt = b ? (HALF_C - last_ones) : last_ones;

        // a slipped window is always followed by a nominal one
        if (win_len != SPS_C) begin
            next_len = SPS_C;
        end else if (e_cnt > l_cnt + CW'(1)) begin
            next_len = SPS_C + CW'(1);
        end else if (l_cnt > e_cnt + CW'(1)) begin
            next_len = SPS_C - CW'(1);
        end else begin
            next_len = SPS_C;
        end

        win_end   = (phase == win_len - CW'(1));
        new_shreg = {shreg, b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= ACC_MID;
            phase       <= '0;
            win_len     <= SPS_C;
            ones_cnt    <= '0;
            first_cnt   <= '0;
            hist        <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            state       <= HUNT;
            o_done_ind  <= 1'b0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
            o_locked    <= 1'b0;
        end else begin
            acc         <= acc_next;
            hist        <= hist_ext[HALF-2:0];
            o_bit_valid <= 1'b0;
            if (win_end) begin
                phase       <= '0;
                ones_cnt    <= '0;
                first_cnt   <= '0;
                win_len     <= next_len;
                o_bit       <= b;
                o_bit_valid <= 1'b1;
                shreg       <= new_shreg[14:0];
                case (state)
                    HUNT: begin
                        if (new_shreg == SYNC_WORD) begin
                            state    <= PAYLOAD;
                            o_locked <= 1'b1;
                            bit_cnt  <= '0;
                        end
                    end
                    PAYLOAD: begin
                        if (bit_cnt == LAST_BIT) begin
                            state      <= DONE;
                            o_done_ind <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                    default: state <= DONE;
                endcase
            end else begin
                phase     <= phase + CW'(1);
                ones_cnt  <= ones_tot;
                first_cnt <= first_tot;
            end
        end
    end

endmodule

// File: tb/tb_rx_slip_demod.sv
// Bench for rx_slip_demod: directed scenarios with randomized payload/noise, checked every
// cycle against an array-based reference of the slicer, slip windows and frame tracking.
module tb_rx_slip_demod;
    localparam int SPS  = 8;
    localparam int HALF = SPS / 2;
    localparam int PAYLOAD_BITS = 64;
    localparam logic [15:0] SYNC = 16'hA5C3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] rx_in = '0;
    logic       done_ind;
    logic       bit_o;
    logic       bit_valid;
    logic       locked;

    int checks = 0;
    int errors = 0;
    int smp[$];
    bit exp_v[$];
    bit exp_b[$];
    bit exp_l[$];
    bit exp_d[$];
    int dut_strobes;
    int lock_strobe;
    int done_strobe;

    rx_slip_demod dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_in    (rx_in),
        .o_done_ind (done_ind),
        .o_bit      (bit_o),
        .o_bit_valid(bit_valid),
        .o_locked   (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lvl(input int base, input int noise);
        int v;
        v = base + int'($urandom_range(0, 2 * noise)) - noise;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    task automatic push_level(input int v, input int n);
        for (int i = 0; i < n; i++) smp.push_back(v);
    endtask

    task automatic push_bits(input logic [31:0] word, input int nb, input int lo, input int hi,
                             input int noise);
        for (int i = nb - 1; i >= 0; i--)
            for (int j = 0; j < SPS; j++) smp.push_back(lvl(word[i] ? hi : lo, noise));
    endtask

    task automatic push_frame(input int lo, input int hi, input int noise, input int npay);
        int left;
        int nb;
        push_bits(32'h5555_5555, 32, lo, hi, noise);
        push_bits({16'h0, SYNC}, 16, lo, hi, noise);
        left = npay;
        while (left > 0) begin
            nb = (left > 32) ? 32 : left;
            push_bits($urandom, nb, lo, hi, noise);
            left -= nb;
        end
    endtask

    // Reference: slice the whole stream, then walk windows over the slice array.
    task automatic build_model();
        bit   s[$];
        int   ends[$];
        bit   bits[$];
        int   acc;
        int   thr;
        int   start;
        int   len;
        int   nxt;
        int   ones;
        int   e;
        int   l;
        bit   bv;
        int   lock_k;
        int   k;
        bit   cur_b;
        bit   lk;
        bit   dn;
        logic [15:0] w;
        exp_v.delete(); exp_b.delete(); exp_l.delete(); exp_d.delete();
        acc = 512 << 4;
        foreach (smp[i]) begin
            thr = acc >> 4;
            s.push_back(smp[i] >= thr);
            acc = acc + smp[i] - thr;
        end
        start = 0;
        len = SPS;
        while (start + len <= smp.size()) begin
            ones = 0;
            for (int j = start; j < start + len; j++) ones += s[j];
            bv = (ones > HALF);
            e = 0;
            for (int j = start; j < start + HALF; j++) e += (s[j] != bv);
            l = 0;
            for (int j = start + len - HALF; j < start + len; j++) l += (s[j] != bv);
            if (len != SPS) nxt = SPS;
            else if (e > l + 1) nxt = SPS + 1;
            else if (l > e + 1) nxt = SPS - 1;
            else nxt = SPS;
            ends.push_back(start + len - 1);
            bits.push_back(bv);
            start += len;
            len = nxt;
        end
        lock_k = -1;
        w = '0;
        foreach (bits[i]) begin
            w = {w[14:0], bits[i]};
            if (lock_k < 0 && w == SYNC) lock_k = i;
        end
        k = 0; cur_b = 0; lk = 0; dn = 0;
        foreach (smp[i]) begin
            if (k < ends.size() && ends[k] == i) begin
                cur_b = bits[k];
                if (lock_k >= 0 && k >= lock_k) lk = 1;
                if (lock_k >= 0 && k >= lock_k + PAYLOAD_BITS) dn = 1;
                exp_v.push_back(1'b1);
                k++;
            end else begin
                exp_v.push_back(1'b0);
            end
            exp_b.push_back(cur_b);
            exp_l.push_back(lk);
            exp_d.push_back(dn);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            rx_in = 10'($urandom_range(0, 1023));
            @(negedge clk);
            check("reset_outputs", {done_ind, bit_o, bit_valid, locked}, 4'b0000);
        end
        reset = 1'b0;
    endtask

    task automatic run_segment(input string tag);
        build_model();
        dut_strobes = 0;
        lock_strobe = 0;
        done_strobe = 0;
        for (int i = 0; i < smp.size(); i++) begin
            rx_in = 10'(smp[i]);
            @(negedge clk);
            if (bit_valid === 1'b1) dut_strobes++;
            if (locked === 1'b1 && lock_strobe == 0) lock_strobe = dut_strobes;
            if (done_ind === 1'b1 && done_strobe == 0) done_strobe = dut_strobes;
            check({tag, "_valid"}, bit_valid, exp_v[i]);
            check({tag, "_bit"}, bit_o, exp_b[i]);
            check({tag, "_locked"}, locked, exp_l[i]);
            check({tag, "_done"}, done_ind, exp_d[i]);
        end
    endtask

    initial begin
        int tmp[$];

        // 1: reset holds every output low
        do_reset(5);

        // 2: ideal aligned frame
        smp.delete();
        push_frame(100, 900, 0, PAYLOAD_BITS);
        push_level(100, 4 * SPS);
        run_segment("t2");
        check("t2_lock_strobe", lock_strobe, 48);
        check("t2_done_strobe", done_strobe, 112);

        // 3: three extra idle samples force slips
        do_reset(2);
        smp.delete();
        push_level(100, 3);
        push_frame(100, 900, 0, PAYLOAD_BITS);
        push_level(100, 4 * SPS);
        run_segment("t3");
        check("t3_done_end", done_ind, 1);

        // 4: alternating bits never lock
        do_reset(2);
        smp.delete();
        for (int i = 0; i < 1250; i++) push_level((i % 2) ? 900 : 100, SPS);
        run_segment("t4");
        check("t4_locked_end", locked, 0);
        check("t4_done_end", done_ind, 0);

        // 5: mid-level idle, then low-swing frame
        do_reset(2);
        smp.delete();
        push_level(500, 200);
        push_frame(400, 600, 0, PAYLOAD_BITS);
        push_level(400, 4 * SPS);
        run_segment("t5");
        check("t5_done_end", done_ind, 1);

        // 6: reset in the middle of a payload, then a complete frame
        do_reset(2);
        smp.delete();
        push_frame(100, 900, 10, 20);
        run_segment("t6a");
        check("t6a_locked_mid", locked, 1);
        check("t6a_done_mid", done_ind, 0);
        do_reset(2);
        smp.delete();
        push_frame(100, 900, 10, PAYLOAD_BITS);
        push_level(100, 4 * SPS);
        run_segment("t6b");
        check("t6b_done_strobe", done_strobe, 112);
        check("t6b_done_end", done_ind, 1);

        // 7: one extra sample every 64 symbols, noisy levels
        do_reset(2);
        smp.delete();
        push_frame(100, 900, 30, PAYLOAD_BITS);
        push_level(100, 4 * SPS);
        tmp.delete();
        foreach (smp[i]) begin
            tmp.push_back(smp[i]);
            if ((i + 1) % (64 * SPS) == 0) tmp.push_back(smp[i]);
        end
        smp = tmp;
        run_segment("t7");
        check("t7_done_end", done_ind, 1);

        // 8: random leading offset and noise
        do_reset(2);
        smp.delete();
        push_level(100, $urandom_range(0, SPS - 1));
        push_frame(100, 900, 40, PAYLOAD_BITS);
        push_level(100, 4 * SPS);
        run_segment("t8");
        check("t8_done_end", done_ind, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
